// File: rtl/sal_sched_pkg.sv
// Shared types for the DDR2 rank command scheduler: command encoding and FAW depth.
package sal_sched_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_t;

  localparam int FAW_SLOTS = 4;

endpackage

// File: rtl/sal_cmd_sched_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr (wrapping) wins.
module sal_rr_arb #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Scan from the farthest offset back towards ptr so the closest requester is written last.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr) + i) % N);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sal_cmd_sched.sv
// Rank-level DDR2 command scheduler: picks one bank request per cycle under
// inter-bank timing (tRRD, tCCD, tWTR, tRTW, tFAW) and registers it to the PHY.
module sal_cmd_sched
  import sal_sched_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int RA_WIDTH  = 14,
  parameter int CA_WIDTH  = 10,
  parameter int T_WIDTH   = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_BANKS-1:0]          act_req_i,
  input  logic [NUM_BANKS-1:0]          rd_req_i,
  input  logic [NUM_BANKS-1:0]          wr_req_i,
  input  logic [NUM_BANKS-1:0]          pre_req_i,
  input  logic [NUM_BANKS-1:0]          ref_req_i,
  input  logic [NUM_BANKS*RA_WIDTH-1:0] ra_i,
  input  logic [NUM_BANKS*CA_WIDTH-1:0] ca_i,
  output logic [NUM_BANKS-1:0]          act_gnt_o,
  output logic [NUM_BANKS-1:0]          rd_gnt_o,
  output logic [NUM_BANKS-1:0]          wr_gnt_o,
  output logic [NUM_BANKS-1:0]          pre_gnt_o,
  output logic [NUM_BANKS-1:0]          ref_gnt_o,
  input  logic [T_WIDTH-1:0]            t_rrd_i,
  input  logic [T_WIDTH-1:0]            t_ccd_i,
  input  logic [T_WIDTH-1:0]            t_wtr_i,
  input  logic [T_WIDTH-1:0]            t_rtw_i,
  input  logic [T_WIDTH-1:0]            t_faw_i,
  output logic                          cmd_valid_o,
  output logic [2:0]                    cmd_o,
  output logic [$clog2(NUM_BANKS)-1:0]  cmd_ba_o,
  output logic [RA_WIDTH-1:0]           cmd_addr_o
);

  localparam int BA_W    = $clog2(NUM_BANKS);
  localparam int CLS_REF = 0;
  localparam int CLS_COL = 1;
  localparam int CLS_PRE = 2;
  localparam int CLS_ACT = 3;

  function automatic logic [T_WIDTH-1:0] load_val(input logic [T_WIDTH-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  function automatic logic [T_WIDTH-1:0] dec_sat(input logic [T_WIDTH-1:0] c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

  logic [BA_W-1:0]     ptr_reg, ptr_next;
  logic [T_WIDTH-1:0]  rrd_cnt_reg, ccd_cnt_reg, wtr_cnt_reg, rtw_cnt_reg;
  logic [T_WIDTH-1:0]  faw_cnt_reg [FAW_SLOTS];
  logic [FAW_SLOTS-1:0] faw_zero, faw_first;

  logic [RA_WIDTH-1:0] ra_bank [NUM_BANKS];
  logic [CA_WIDTH-1:0] ca_bank [NUM_BANKS];

  logic [NUM_BANKS-1:0] cls_req [4];
  logic [NUM_BANKS-1:0] cls_gnt [4];
  logic [BA_W-1:0]      cls_idx [4];
  logic [3:0]           cls_any;

  logic                 rd_ok, wr_ok, act_ok;
  logic [1:0]           win_cls;
  logic                 win_any, gnt_en;
  logic [BA_W-1:0]      win_idx;
  cmd_t                 gnt_cmd;
  logic [RA_WIDTH-1:0]  addr_next;

  cmd_t                 cmd_reg;
  logic                 cmd_valid_reg;
  logic [BA_W-1:0]      cmd_ba_reg;
  logic [RA_WIDTH-1:0]  cmd_addr_reg;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_addr
    assign ra_bank[gi] = ra_i[gi*RA_WIDTH +: RA_WIDTH];
    assign ca_bank[gi] = ca_i[gi*CA_WIDTH +: CA_WIDTH];
  end

  for (genvar gi = 0; gi < FAW_SLOTS; gi++) begin : g_faw_zero
    assign faw_zero[gi] = (faw_cnt_reg[gi] == '0);
  end
  assign faw_first = faw_zero & (~faw_zero + 1'b1);

  assign rd_ok  = (ccd_cnt_reg == '0) && (wtr_cnt_reg == '0);
  assign wr_ok  = (ccd_cnt_reg == '0) && (rtw_cnt_reg == '0);
  assign act_ok = (rrd_cnt_reg == '0) && (|faw_zero);

  // A bank asserting RD and WR together is treated as RD only.
  assign cls_req[CLS_REF] = ref_req_i;
  assign cls_req[CLS_COL] = (rd_req_i & {NUM_BANKS{rd_ok}}) |
                            (wr_req_i & ~rd_req_i & {NUM_BANKS{wr_ok}});
  assign cls_req[CLS_PRE] = pre_req_i;
  assign cls_req[CLS_ACT] = act_req_i & {NUM_BANKS{act_ok}};

  for (genvar gi = 0; gi < 4; gi++) begin : g_arb
    sal_rr_arb #(.N(NUM_BANKS), .IW(BA_W)) u_arb (
      .req (cls_req[gi]),
      .ptr (ptr_reg),
      .gnt (cls_gnt[gi]),
      .idx (cls_idx[gi]),
      .any (cls_any[gi])
    );
  end

  // Class index doubles as priority: the lowest-indexed class with a winner takes the cycle.
  always_comb begin
    win_cls = 2'd0;
    win_any = 1'b0;
    for (int c = 3; c >= 0; c--) begin
      if (cls_any[c]) begin
        win_cls = 2'(c);
        win_any = 1'b1;
      end
    end
  end

  assign gnt_en  = rst_n && win_any;
  assign win_idx = cls_idx[win_cls];

  assign ref_gnt_o = (gnt_en && win_cls == 2'(CLS_REF)) ? cls_gnt[CLS_REF] : '0;
  assign pre_gnt_o = (gnt_en && win_cls == 2'(CLS_PRE)) ? cls_gnt[CLS_PRE] : '0;
  assign act_gnt_o = (gnt_en && win_cls == 2'(CLS_ACT)) ? cls_gnt[CLS_ACT] : '0;
  assign rd_gnt_o  = (gnt_en && win_cls == 2'(CLS_COL)) ? (cls_gnt[CLS_COL] & rd_req_i) : '0;
  assign wr_gnt_o  = (gnt_en && win_cls == 2'(CLS_COL)) ? (cls_gnt[CLS_COL] & ~rd_req_i) : '0;

  always_comb begin
    gnt_cmd   = CMD_NOP;
    addr_next = '0;
    if (gnt_en) begin
      case (win_cls)
        2'(CLS_REF): gnt_cmd = CMD_REF;
        2'(CLS_COL): begin
          gnt_cmd   = rd_req_i[win_idx] ? CMD_RD : CMD_WR;
          addr_next = RA_WIDTH'(ca_bank[win_idx]);
        end
        2'(CLS_PRE): gnt_cmd = CMD_PRE;
        default: begin
          gnt_cmd   = CMD_ACT;
          addr_next = ra_bank[win_idx];
        end
      endcase
    end
  end

  assign ptr_next = !gnt_en ? ptr_reg :
                    (win_idx == BA_W'(NUM_BANKS - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg       <= '0;
      rrd_cnt_reg   <= '0;
      ccd_cnt_reg   <= '0;
      wtr_cnt_reg   <= '0;
      rtw_cnt_reg   <= '0;
      cmd_valid_reg <= 1'b0;
      cmd_reg       <= CMD_NOP;
      cmd_ba_reg    <= '0;
      cmd_addr_reg  <= '0;
    end else begin
      ptr_reg     <= ptr_next;
      rrd_cnt_reg <= (gnt_cmd == CMD_ACT) ? load_val(t_rrd_i) : dec_sat(rrd_cnt_reg);
      ccd_cnt_reg <= (gnt_cmd == CMD_RD || gnt_cmd == CMD_WR) ? load_val(t_ccd_i)
                                                              : dec_sat(ccd_cnt_reg);
      wtr_cnt_reg <= (gnt_cmd == CMD_WR) ? load_val(t_wtr_i) : dec_sat(wtr_cnt_reg);
      rtw_cnt_reg <= (gnt_cmd == CMD_RD) ? load_val(t_rtw_i) : dec_sat(rtw_cnt_reg);
      cmd_valid_reg <= gnt_en;
      cmd_reg       <= gnt_cmd;
      if (gnt_en) begin
        cmd_ba_reg   <= win_idx;
        cmd_addr_reg <= addr_next;
      end
    end
  end

  // Each ACT claims the lowest free slot; the window is full when no slot is zero.
  for (genvar gi = 0; gi < FAW_SLOTS; gi++) begin : g_faw
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        faw_cnt_reg[gi] <= '0;
      end else if (gnt_cmd == CMD_ACT && faw_first[gi]) begin
        faw_cnt_reg[gi] <= load_val(t_faw_i);
      end else begin
        faw_cnt_reg[gi] <= dec_sat(faw_cnt_reg[gi]);
      end
    end
  end

  assign cmd_valid_o = cmd_valid_reg;
  assign cmd_o       = cmd_reg;
  assign cmd_ba_o    = cmd_ba_reg;
  assign cmd_addr_o  = cmd_addr_reg;

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Bench for sal_cmd_sched: directed scenarios plus random traffic, all checked
// against an earliest-issue-cycle reference model.
module tb_sal_cmd_sched;

  localparam int NB  = 4;
  localparam int RAW = 14;
  localparam int CAW = 10;
  localparam int TW  = 5;

  logic               clk, rst_n;
  logic [NB-1:0]      act_req, rd_req, wr_req, pre_req, ref_req;
  logic [NB*RAW-1:0]  ra;
  logic [NB*CAW-1:0]  ca;
  logic [NB-1:0]      act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic [TW-1:0]      t_rrd, t_ccd, t_wtr, t_rtw, t_faw;
  logic               cmd_valid;
  logic [2:0]         cmd;
  logic [1:0]         cmd_ba;
  logic [RAW-1:0]     cmd_addr;

  sal_cmd_sched #(.NUM_BANKS(NB), .RA_WIDTH(RAW), .CA_WIDTH(CAW), .T_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .act_req_i(act_req), .rd_req_i(rd_req), .wr_req_i(wr_req),
    .pre_req_i(pre_req), .ref_req_i(ref_req),
    .ra_i(ra), .ca_i(ca),
    .act_gnt_o(act_gnt), .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt),
    .pre_gnt_o(pre_gnt), .ref_gnt_o(ref_gnt),
    .t_rrd_i(t_rrd), .t_ccd_i(t_ccd), .t_wtr_i(t_wtr), .t_rtw_i(t_rtw), .t_faw_i(t_faw),
    .cmd_valid_o(cmd_valid), .cmd_o(cmd), .cmd_ba_o(cmd_ba), .cmd_addr_o(cmd_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: earliest cycle at which each constraint is satisfied.
  int cyc, act_at, ccd_at, wtr_at, rtw_at, ptr;
  int faw_exp[$];
  logic [NB-1:0]  m_act, m_rd, m_wr, m_pre, m_ref;
  int             m_cmd, m_bank;
  logic [RAW-1:0] m_addr;
  logic           e_valid;
  logic [2:0]     e_cmd;
  logic [1:0]     e_ba;
  logic [RAW-1:0] e_addr;

  logic [NB-1:0] exp_rrd [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0010};
  logic [NB-1:0] exp_wrap [5] = '{4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [NB-1:0] el, input int p);
    for (int i = 0; i < NB; i++) begin
      if (el[(p + i) % NB]) return (p + i) % NB;
    end
    return -1;
  endfunction

  task automatic model_eval();
    int busy = 0;
    int b;
    bit act_ok, rd_ok, wr_ok;
    logic [NB-1:0] col;
    foreach (faw_exp[i]) if (cyc < faw_exp[i]) busy++;
    act_ok = (cyc >= act_at) && (busy < 4);
    rd_ok  = (cyc >= ccd_at) && (cyc >= wtr_at);
    wr_ok  = (cyc >= ccd_at) && (cyc >= rtw_at);
    for (int k = 0; k < NB; k++) col[k] = rd_req[k] ? rd_ok : (wr_req[k] && wr_ok);
    m_act = '0; m_rd = '0; m_wr = '0; m_pre = '0; m_ref = '0;
    m_cmd = 0; m_bank = -1; m_addr = '0;
    b = pick(ref_req, ptr);
    if (b >= 0) begin m_cmd = 5; m_ref[b] = 1'b1; end
    else begin
      b = pick(col, ptr);
      if (b >= 0) begin
        if (rd_req[b]) begin m_cmd = 2; m_rd[b] = 1'b1; end
        else begin m_cmd = 3; m_wr[b] = 1'b1; end
        m_addr = RAW'(ca[b*CAW +: CAW]);
      end else begin
        b = pick(pre_req, ptr);
        if (b >= 0) begin m_cmd = 4; m_pre[b] = 1'b1; end
        else begin
          b = pick(act_req & {NB{act_ok}}, ptr);
          if (b >= 0) begin m_cmd = 1; m_act[b] = 1'b1; m_addr = ra[b*RAW +: RAW]; end
        end
      end
    end
    m_bank = b;
  endtask

  task automatic sample(input string tag);
    @(negedge clk);
    model_eval();
    chk({tag, ".act_gnt"}, 32'(act_gnt), 32'(m_act));
    chk({tag, ".rd_gnt"},  32'(rd_gnt),  32'(m_rd));
    chk({tag, ".wr_gnt"},  32'(wr_gnt),  32'(m_wr));
    chk({tag, ".pre_gnt"}, 32'(pre_gnt), 32'(m_pre));
    chk({tag, ".ref_gnt"}, 32'(ref_gnt), 32'(m_ref));
    chk({tag, ".cmd_valid"}, 32'(cmd_valid), 32'(e_valid));
    chk({tag, ".cmd"},       32'(cmd),       32'(e_cmd));
    chk({tag, ".cmd_ba"},    32'(cmd_ba),    32'(e_ba));
    chk({tag, ".cmd_addr"},  32'(cmd_addr),  32'(e_addr));
  endtask

  task automatic advance();
    if (m_cmd != 0) begin
      case (m_cmd)
        1: begin act_at = cyc + int'(t_rrd); faw_exp.push_back(cyc + int'(t_faw)); end
        2: begin ccd_at = cyc + int'(t_ccd); rtw_at = cyc + int'(t_rtw); end
        3: begin ccd_at = cyc + int'(t_ccd); wtr_at = cyc + int'(t_wtr); end
        default: ;
      endcase
      ptr     = (m_bank + 1) % NB;
      e_valid = 1'b1;
      e_cmd   = 3'(m_cmd);
      e_ba    = 2'(m_bank);
      e_addr  = m_addr;
      $display("cyc=%0d grant cmd=%0d bank=%0d addr=0x%0h", cyc, m_cmd, m_bank, m_addr);
    end else begin
      e_valid = 1'b0;
      e_cmd   = 3'd0;
    end
    while (faw_exp.size() > 0 && faw_exp[0] <= cyc) void'(faw_exp.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_reqs();
    act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
  endtask

  task automatic set_t(input int rrd, input int ccd, input int wtr, input int rtw, input int faw);
    t_rrd = TW'(rrd); t_ccd = TW'(ccd); t_wtr = TW'(wtr); t_rtw = TW'(rtw); t_faw = TW'(faw);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst.grants", 32'({act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    act_at = 0; ccd_at = 0; wtr_at = 0; rtw_at = 0; ptr = 0;
    faw_exp.delete();
    e_valid = 1'b0; e_cmd = 3'd0; e_ba = 2'd0; e_addr = '0;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; cyc = 0;
    clear_reqs(); set_t(0, 0, 0, 0, 0);
    ra = '0; ca = '0;
    #1;
    do_reset();

    // Reset state and single ACT with latency-1 command output.
    chk("rst.cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst.cmd", 32'(cmd), 32'd0);
    chk("rst.ba_addr", 32'({cmd_ba, cmd_addr}), 32'd0);
    act_req = 4'b0001; ra[RAW-1:0] = 14'h123;
    sample("act1"); chk("act1.gnt", 32'(act_gnt), 32'b0001); advance();
    clear_reqs();
    sample("act1b");
    chk("act1.cmd", 32'(cmd), 32'd1);
    chk("act1.ba", 32'(cmd_ba), 32'd0);
    chk("act1.addr", 32'(cmd_addr), 32'h123);
    advance();

    // tRRD=3 spacing between two banks.
    do_reset(); set_t(3, 0, 0, 0, 0); act_req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      sample("rrd"); chk("rrd.act_gnt", 32'(act_gnt), 32'(exp_rrd[k])); advance();
    end
    clear_reqs();

    // tFAW=20 window stalls the fifth ACT.
    do_reset(); set_t(2, 0, 0, 0, 20); act_req = 4'b1111;
    for (int k = 0; k <= 20; k++) begin
      logic [NB-1:0] e;
      e = (k == 0) ? 4'b0001 : (k == 2) ? 4'b0010 : (k == 4) ? 4'b0100 :
          (k == 6) ? 4'b1000 : (k == 20) ? 4'b0001 : 4'b0000;
      sample("faw"); chk("faw.act_gnt", 32'(act_gnt), 32'(e)); advance();
    end
    clear_reqs();

    // Class priority: column beats ACT, REF beats column.
    do_reset(); set_t(0, 0, 0, 0, 0);
    rd_req = 4'b0100; act_req = 4'b0010;
    sample("prio_col");
    chk("prio_col.rd", 32'(rd_gnt), 32'b0100); chk("prio_col.act", 32'(act_gnt), 32'b0000);
    advance(); clear_reqs();
    do_reset();
    ref_req = 4'b1000; rd_req = 4'b0001;
    sample("prio_ref");
    chk("prio_ref.ref", 32'(ref_gnt), 32'b1000); chk("prio_ref.rd", 32'(rd_gnt), 32'b0000);
    advance(); clear_reqs();

    // Write-to-read turnaround.
    do_reset(); set_t(0, 2, 4, 0, 0);
    wr_req = 4'b0001;
    sample("wtr"); chk("wtr.wr", 32'(wr_gnt), 32'b0001); advance();
    wr_req = '0; rd_req = 4'b0010;
    for (int k = 1; k <= 4; k++) begin
      sample("wtr"); chk("wtr.rd", 32'(rd_gnt), (k == 4) ? 32'b0010 : 32'b0000); advance();
    end
    clear_reqs();

    // Round-robin with pointer wrap under tCCD=2.
    do_reset(); set_t(0, 2, 0, 0, 0); rd_req = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      sample("wrap"); chk("wrap.rd", 32'(rd_gnt), 32'(exp_wrap[k])); advance();
    end
    clear_reqs();

    // Reset while tRRD counter is loaded: ACT is granted right after release.
    do_reset(); set_t(6, 0, 0, 0, 0); act_req = 4'b0001;
    sample("rstmid"); advance();
    do_reset();
    sample("rstmid2"); chk("rstmid.act", 32'(act_gnt), 32'b0001); advance();
    clear_reqs();

    // Random traffic against the reference model.
    for (int blk = 0; blk < 8; blk++) begin
      set_t($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
            $urandom_range(0, 6), $urandom_range(0, 24));
      for (int n = 0; n < 60; n++) begin
        act_req = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
        rd_req  = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
        wr_req  = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
        pre_req = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
        ref_req = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
        ra = (NB*RAW)'({$urandom(), $urandom()});
        ca = (NB*CAW)'({$urandom(), $urandom()});
        if ($urandom_range(0, 99) == 0) do_reset();
        sample("rand");
        advance();
      end
    end
    clear_reqs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
